fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a hardware return-address stack.
// PC drives the ROM address combinationally; the ROM word and its address are
// registered for decode. CALL/RET are resolved here, branches come from execute.
// Optional build macro FETCH_STACK_GUARD_EN: stack overflow/underflow raises a
// sticky oError and halts fetch. Without it the stack is circular and an empty
// pop restarts at address 0.
//
// Handshake: there is no ready/valid pair. oValid qualifies oInstruction/oPC
// for exactly the cycles decode should consume them. iStall (decode not ready)
// freezes every fetch register. iBranchTaken is a single-cycle redirect that
// wins over iStall and squashes the word currently held for decode.

`ifndef CALL
`define CALL 4'hA
`endif
`ifndef RET
`define RET 4'hB
`endif

module fetch_unit #(
  parameter int ADDR_W      = 16,
  parameter int INSTR_W     = 28,
  parameter int STACK_DEPTH = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oValid,
  output logic               oError,
  output logic               oDebugState
);

  localparam int SP_W    = $clog2(STACK_DEPTH);
  // Logical nesting depth needs to count past STACK_DEPTH so that a circular
  // stack still knows how many pops are backed by a push.
  localparam int DEPTH_W = SP_W + 2;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [SP_W-1:0]      sp_q, sp_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [ADDR_W-1:0]    stack_mem [STACK_DEPTH];
  logic [INSTR_W-1:0]   instr_q;
  logic [ADDR_W-1:0]    opc_q;
  logic                 valid_q, valid_d;
  logic                 capture;
  logic                 push_en;
  logic                 fault;

  logic [3:0]           opcode;
  logic                 is_call, is_ret;
  logic [ADDR_W-1:0]    call_target;
  logic [ADDR_W-1:0]    pc_inc;
  logic [SP_W-1:0]      rd_idx;
  logic                 stack_full, stack_empty;

  assign opcode      = iInstruction[27:24];
  assign is_call     = (opcode == `CALL);
  assign is_ret      = (opcode == `RET);
  assign call_target = {{(ADDR_W-8){1'b0}}, iInstruction[23:16]};
  assign pc_inc      = pc_q + ADDR_W'(1);
  assign rd_idx      = sp_q - SP_W'(1);
  assign stack_full  = (depth_q >= DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);

  assign oAddress     = pc_q;
  assign oInstruction = instr_q;
  assign oPC          = opc_q;
  assign oValid       = valid_q;
  assign oDebugState  = (state_q == HALT);

  // Next-state, PC selection and stack control for one fetch cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    valid_d = valid_q;
    capture = 1'b0;
    push_en = 1'b0;
    fault   = 1'b0;
    if (state_q == HALT) begin
      valid_d = 1'b0;
    end else if (iBranchTaken) begin
      pc_d    = iBranchTarget;
      valid_d = 1'b0;
    end else if (!iStall) begin
      if (is_call) begin
`ifdef FETCH_STACK_GUARD_EN
        fault = stack_full;
`endif
        if (!fault) begin
          push_en = 1'b1;
          sp_d    = sp_q + SP_W'(1);
          depth_d = (depth_q == '1) ? depth_q : depth_q + DEPTH_W'(1);
          pc_d    = call_target;
          capture = 1'b1;
          valid_d = 1'b1;
        end
      end else if (is_ret) begin
`ifdef FETCH_STACK_GUARD_EN
        fault = stack_empty;
`endif
        if (!fault) begin
          capture = 1'b1;
          valid_d = 1'b1;
          if (stack_empty) begin
            pc_d = '0;
          end else begin
            pc_d    = stack_mem[rd_idx];
            sp_d    = rd_idx;
            depth_d = depth_q - DEPTH_W'(1);
          end
        end
      end else begin
        pc_d    = pc_inc;
        capture = 1'b1;
        valid_d = 1'b1;
      end
      if (fault) begin
        state_d = HALT;
        valid_d = 1'b0;
      end
    end
  end

  // Fetch state, stack pointer and decode-side output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      sp_q    <= '0;
      depth_q <= '0;
      instr_q <= '0;
      opc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      valid_q <= valid_d;
      if (capture) begin
        instr_q <= iInstruction;
        opc_q   <= pc_q;
      end
    end
  end

  // Return-address storage; contents are meaningless until pushed.
  always_ff @(posedge Clock) begin
    if (push_en) begin
      stack_mem[sp_q] <= pc_inc;
    end
  end

`ifdef FETCH_STACK_GUARD_EN
  logic err_q;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      err_q <= 1'b0;
    end else if (fault) begin
      err_q <= 1'b1;
    end
  end

  assign oError = err_q;
`else
  logic unused_ok;
  assign unused_ok = stack_full;
  assign oError    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit driving a combinational ROM
// model. Builds with or without FETCH_STACK_GUARD_EN.
module tb_fetch_unit;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 28;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;

  logic               Clock;
  logic               Reset;
  logic [ADDR_W-1:0]  oAddress;
  logic [INSTR_W-1:0] iInstruction;
  logic               iStall;
  logic               iBranchTaken;
  logic [ADDR_W-1:0]  iBranchTarget;
  logic [INSTR_W-1:0] oInstruction;
  logic [ADDR_W-1:0]  oPC;
  logic               oValid;
  logic               oError;
  logic               oDebugState;

  logic [INSTR_W-1:0] rom [256];
  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .STACK_DEPTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
    .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oInstruction(oInstruction), .oPC(oPC), .oValid(oValid), .oError(oError),
    .oDebugState(oDebugState)
  );

  assign iInstruction = rom[oAddress[7:0]];

  // Clock
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [INSTR_W-1:0] w_call(input int t);
    logic [7:0] t8;
    t8 = 8'(t);
    return {OP_CALL, t8, 16'h0000};
  endfunction

  function automatic logic [INSTR_W-1:0] w_ret();
    return {OP_RET, 24'h000000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic reset_pulse();
    Reset = 1'b0;
    iStall = 1'b0;
    iBranchTaken = 1'b0;
    iBranchTarget = '0;
    step();
    Reset = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"},  32'(oAddress), 32'h0);
    chk({tag, "_pc"},    32'(oPC), 32'h0);
    chk({tag, "_instr"}, 32'(oInstruction), 32'h0);
    chk({tag, "_valid"}, 32'(oValid), 32'h0);
    chk({tag, "_err"},   32'(oError), 32'h0);
    chk({tag, "_halt"},  32'(oDebugState), 32'h0);
  endtask

  initial begin
    int exp_ret [10];
    // ROM image: plain words everywhere, then the CALL/RET program pieces.
    for (int i = 0; i < 256; i++) rom[i] = 28'(i);
    rom[5]   = w_call(32);
    rom[35]  = w_ret();
    rom[16]  = w_call(40);
    rom[51]  = w_ret();
    for (int k = 0; k < 9; k++) begin
      rom[100 + 10*k] = w_call(110 + 10*k);
      rom[101 + 10*k] = w_ret();
    end
    rom[190] = w_ret();

    // Reset state is visible before any clock edge.
    Reset = 1'b0;
    iStall = 1'b0;
    iBranchTaken = 1'b0;
    iBranchTarget = '0;
    #2;
    chk_zero("reset");
    step();
    Reset = 1'b1;

    // Sequential fetch: after edge k the ROM address is k, oPC is k-1.
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("seq_addr", 32'(oAddress), 32'(k));
      chk("seq_pc", 32'(oPC), 32'(k - 1));
      chk("seq_valid", 32'(oValid), 32'h1);
    end
    chk("seq_instr", 32'(oInstruction), 32'h4);

    // CALL at 5 to 32, run to RET at 35, return to 6.
    step();
    chk("call_addr", 32'(oAddress), 32'd32);
    chk("call_pc", 32'(oPC), 32'd5);
    chk("call_instr", 32'(oInstruction), 32'(w_call(32)));
    for (int a = 33; a <= 35; a++) begin
      step();
      chk("sub_addr", 32'(oAddress), 32'(a));
    end
    step();
    chk("ret_addr", 32'(oAddress), 32'd6);
    chk("ret_pc", 32'(oPC), 32'd35);
    chk("ret_instr", 32'(oInstruction), 32'(w_ret()));
    step();
    chk("after_ret_addr", 32'(oAddress), 32'd7);

    // Stall alone holds everything.
    iStall = 1'b1;
    step();
    chk("stall_addr", 32'(oAddress), 32'd7);
    chk("stall_pc", 32'(oPC), 32'd6);
    chk("stall_valid", 32'(oValid), 32'h1);
    chk("stall_instr", 32'(oInstruction), 32'd6);

    // Branch wins over stall and squashes.
    iBranchTaken = 1'b1;
    iBranchTarget = 16'd15;
    step();
    chk("br_stall_addr", 32'(oAddress), 32'd15);
    chk("br_stall_valid", 32'(oValid), 32'h0);
    iBranchTaken = 1'b0;
    iStall = 1'b0;
    step();
    chk("post_br_addr", 32'(oAddress), 32'd16);
    chk("post_br_pc", 32'(oPC), 32'd15);
    chk("post_br_valid", 32'(oValid), 32'h1);

    // Branch and CALL (rom[16]) together: branch target, no push.
    iBranchTaken = 1'b1;
    iBranchTarget = 16'd50;
    step();
    chk("br_call_addr", 32'(oAddress), 32'd50);
    chk("br_call_valid", 32'(oValid), 32'h0);
    iBranchTaken = 1'b0;
    step();
    chk("br_call_next", 32'(oAddress), 32'd51);

    // RET at 51 on an empty stack (also proves the CALLs above left nothing).
    step();
`ifdef FETCH_STACK_GUARD_EN
    chk("empty_ret_addr", 32'(oAddress), 32'd51);
    chk("empty_ret_err", 32'(oError), 32'h1);
    chk("empty_ret_valid", 32'(oValid), 32'h0);
    chk("empty_ret_halt", 32'(oDebugState), 32'h1);
    iBranchTaken = 1'b1;
    iBranchTarget = 16'd70;
    step();
    iBranchTaken = 1'b0;
    chk("halt_frozen_addr", 32'(oAddress), 32'd51);
    chk("halt_sticky_err", 32'(oError), 32'h1);
`else
    chk("empty_ret_addr", 32'(oAddress), 32'd0);
    chk("empty_ret_pc", 32'(oPC), 32'd51);
    chk("empty_ret_valid", 32'(oValid), 32'h1);
    chk("empty_ret_err", 32'(oError), 32'h0);
`endif

    // Nine nested CALLs from 100.
    reset_pulse();
    iBranchTaken = 1'b1;
    iBranchTarget = 16'd100;
    step();
    iBranchTaken = 1'b0;
    chk("nest_start", 32'(oAddress), 32'd100);
    for (int k = 0; k < 9; k++) begin
      step();
`ifdef FETCH_STACK_GUARD_EN
      if (k == 8) begin
        chk("ovf_addr", 32'(oAddress), 32'd180);
        chk("ovf_err", 32'(oError), 32'h1);
        chk("ovf_valid", 32'(oValid), 32'h0);
        step();
        chk("ovf_frozen", 32'(oAddress), 32'd180);
      end else begin
        chk("nest_addr", 32'(oAddress), 32'(110 + 10*k));
      end
`else
      chk("nest_addr", 32'(oAddress), 32'(110 + 10*k));
      chk("nest_pc", 32'(oPC), 32'(100 + 10*k));
`endif
    end
`ifndef FETCH_STACK_GUARD_EN
    // Newest eight returns, then the overwritten slot, then empty -> 0.
    exp_ret = '{181, 171, 161, 151, 141, 131, 121, 111, 181, 0};
    for (int r = 0; r < 10; r++) begin
      step();
      chk("unwind_addr", 32'(oAddress), 32'(exp_ret[r]));
      chk("unwind_valid", 32'(oValid), 32'h1);
    end
    chk("unwind_err", 32'(oError), 32'h0);
`endif

    // Reset asserted mid CALL chain clears outputs without a clock edge.
    reset_pulse();
    iBranchTaken = 1'b1;
    iBranchTarget = 16'd100;
    step();
    iBranchTaken = 1'b0;
    step();
    step();
    step();
    chk("chain_addr", 32'(oAddress), 32'd130);
    #3;
    Reset = 1'b0;
    #1;
    chk_zero("mid_reset");
    step();
    Reset = 1'b1;

    // PC wrap from 16'hFFFF to 0.
    iBranchTaken = 1'b1;
    iBranchTarget = 16'hFFFF;
    step();
    iBranchTaken = 1'b0;
    chk("wrap_pre", 32'(oAddress), 32'hFFFF);
    step();
    chk("wrap_addr", 32'(oAddress), 32'h0);
    chk("wrap_pc", 32'(oPC), 32'hFFFF);
    chk("wrap_instr", 32'(oInstruction), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
